riscv_mc_control: RTL and testbench
===================================

Name: riscv_mc_control

Overview:
Parametrised multicycle RISC-V control unit, the next generation of the team's 5-state LD/SD/BEQ/R-type sequencer. It adds OP-IMM, BNE and JAL, a memory-ready wait handshake and an illegal-opcode trap state. It also adds a retired-instruction counter and resolves conditional PC writes internally from the ALU zero flag. It drives the existing multicycle datapath's control inputs and reads opcode/funct3 back from the IR.

Parameters:
MEM_WAIT_EN, 1, 1: FETCH/MEM states stall until mem_ready; 0: mem_ready ignored (single-cycle memory)
CNT_W, 32, width of the retired-instruction counter
JAL_EN, 1, 1: JAL decoded; 0: JAL opcode treated as illegal

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12], branch condition select
zero  in  1  ALU zero flag, current cycle
mem_ready  in  1  memory access completes this cycle
alu_op  out  2  00 add, 01 sub, 10 R-type funct, 11 I-type funct
alu_src_a  out  2  00 PC, 01 reg A, 10 OldPC
alu_src_b  out  2  00 reg B, 01 const 4, 10 immediate
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (link)
pc_source  out  1  0 ALU result, 1 ALUOut register
mem_read, mem_write, i_or_d, reg_write, ir_write, pc_write  out  1 each  datapath strobes (i_or_d 0 = instruction address)
state  out  4  current state, debug
illegal  out  1  high while in TRAP
instret  out  CNT_W  retired-instruction count

Behaviour:
- Opcodes: LOAD 0000011, STORE 0100011, BRANCH 1100011 (funct3 000 BEQ, 001 BNE, others illegal), OP 0110011, OP-IMM 0010011, JAL 1101111.
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_LOAD=3, LOAD_WB=4, MEM_STORE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JAL=10, TRAP=11. Codes 12-15 are unreachable; if entered, go to TRAP.
- Reset (async, reset_n=0): state=FETCH, instret=0. All outputs take their FETCH values with mem_ready treated as 0: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_write=0, ir_write=0. All other strobes 0.
- Reset mid-operation aborts the instruction; it is not counted.
- Let rdy = mem_ready when MEM_WAIT_EN=1, else 1.
- FETCH: mem_read=1, i_or_d=0, ALU=PC+4, pc_source=0. ir_write=pc_write=rdy (Mealy). Next = rdy ? DECODE : FETCH.
- DECODE: ALU=OldPC+imm (alu_src_a=10, alu_src_b=10, add). Next: LOAD/STORE→MEM_ADDR, OP→EXEC_R, OP-IMM→EXEC_I, BRANCH with funct3 000/001→BRANCH, JAL (JAL_EN=1)→JAL, else→TRAP.
- MEM_ADDR: A+imm, add. Next: LOAD→MEM_LOAD, STORE→MEM_STORE.
- MEM_LOAD: mem_read=1, i_or_d=1. Next = rdy ? LOAD_WB : MEM_LOAD.
- LOAD_WB: reg_write=1, mem_to_reg=01. Next FETCH; retires.
- MEM_STORE: mem_write=1, i_or_d=1; mem_write is held for the whole wait. Next = rdy ? FETCH : MEM_STORE; retires when leaving.
- EXEC_R: A op B, alu_op=10. EXEC_I: A op imm, alu_op=11. Both go to ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=00. Next FETCH; retires.
- BRANCH: A-B, alu_op=01, pc_source=1. pc_write = (funct3==000) ? zero : ~zero (Mealy). Next FETCH; retires whether taken or not.
- JAL: reg_write=1, mem_to_reg=10 (PC already PC+4), pc_write=1, pc_source=1. Next FETCH; retires.
- TRAP: illegal=1, all strobes 0. Sticky until reset. No retire.
- instret increments by 1 on each retiring transition, and wraps modulo 2^CNT_W.
- In every state, any strobe not listed is 0. ALU mux outputs not listed default to 00.
- Latency in cycles with zero wait: LOAD 5, STORE 4, R/I 4, BRANCH 3, JAL 3. Each mem_ready=0 cycle in FETCH/MEM_LOAD/MEM_STORE adds 1.

Test Plan:
- Reset held low, then released; MEM_WAIT_EN=1, mem_ready=1, opcode=0110011 -> state sequence 0,1,6,8,0. reg_write=1 only in ALU_WB. instret=1 after 4 cycles.
- LOAD with mem_ready=0 for 2 cycles in MEM_LOAD -> mem_read and i_or_d held at 1 across 3 cycles. LOAD_WB has mem_to_reg=01. Total 7 cycles; instret +1.
- BRANCH funct3=001, zero=0 -> pc_write=1, pc_source=1 in BRANCH. Repeat with zero=1 -> pc_write=0. Both retire.
- JAL (JAL_EN=1) -> 3 cycles; in JAL reg_write=1, mem_to_reg=10, pc_write=1. With JAL_EN=0 -> TRAP, illegal=1 held for 10 cycles, instret unchanged.
- Fetch with mem_ready=0 for 3 cycles -> ir_write=pc_write=0 for those cycles, then 1 for one cycle. With MEM_WAIT_EN=0 -> ir_write=1 in the first FETCH cycle regardless of mem_ready.
- CNT_W=4: retire 17 R-type instructions -> instret=1. Assert reset_n=0 mid-EXEC_R -> state=0 and instret=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_mc_control.sv
// Multicycle RISC-V control sequencer: LOAD/STORE/OP/OP-IMM/BEQ/BNE/JAL with
// memory-ready stalls, a sticky illegal-opcode trap and a retired-instruction counter.
module riscv_mc_control #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 32,
  parameter bit JAL_EN      = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       alu_op,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       mem_to_reg,
  output logic             pc_source,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_LOAD = 4'd3,
    S_LOAD_WB = 4'd4, S_MEM_STORE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7,
    S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  logic             rdy;

  // Gating with reset_n keeps the Mealy IR/PC strobes low while reset is held.
  assign rdy = (MEM_WAIT_EN ? mem_ready : 1'b1) & reset_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    alu_op     = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    mem_to_reg = 2'b00;
    pc_source  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_write  = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target computed speculatively from OldPC while decoding.
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_OP:             state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = JAL_EN ? S_JAL : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        if (opcode == OP_LOAD)       state_d = S_MEM_LOAD;
        else if (opcode == OP_STORE) state_d = S_MEM_STORE;
        else                         state_d = S_TRAP;
      end
      S_MEM_LOAD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (rdy) state_d = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_STORE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_source = 1'b1;
        pc_write  = funct3[0] ? ~zero : zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        pc_write   = 1'b1;
        pc_source  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  illegal = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  assign state   = state_q;
  assign instret = instret_q;
endmodule

// File: tb/tb_riscv_mc_control.sv
// Bench for riscv_mc_control: directed vector table, random instruction stream and
// hand-written reset/wrap sequences, checked against a per-instruction cycle-schedule model.
module tb_riscv_mc_control;
  logic clock = 1'b0;
  logic reset_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic zero, mem_ready;

  logic [1:0] aop0, sa0, sb0, m2r0, aop1, sa1, sb1, m2r1;
  logic pcs0, mrd0, mwr0, iod0, rw0, irw0, pcw0, ill0;
  logic pcs1, mrd1, mwr1, iod1, rw1, irw1, pcw1, ill1;
  logic [3:0]  st0, st1;
  logic [31:0] ir0;
  logic [3:0]  ir1;

  always #5 clock = ~clock;

  riscv_mc_control #(.MEM_WAIT_EN(1'b1), .CNT_W(32), .JAL_EN(1'b1)) u0 (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .alu_op(aop0), .alu_src_a(sa0), .alu_src_b(sb0),
    .mem_to_reg(m2r0), .pc_source(pcs0), .mem_read(mrd0), .mem_write(mwr0),
    .i_or_d(iod0), .reg_write(rw0), .ir_write(irw0), .pc_write(pcw0), .state(st0),
    .illegal(ill0), .instret(ir0));

  riscv_mc_control #(.MEM_WAIT_EN(1'b0), .CNT_W(4), .JAL_EN(1'b0)) u1 (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .alu_op(aop1), .alu_src_a(sa1), .alu_src_b(sb1),
    .mem_to_reg(m2r1), .pc_source(pcs1), .mem_read(mrd1), .mem_write(mwr1),
    .i_or_d(iod1), .reg_write(rw1), .ir_write(irw1), .pc_write(pcw1), .state(st1),
    .illegal(ill1), .instret(ir1));

  localparam logic [6:0] LD = 7'b0000011, SD = 7'b0100011, BR = 7'b1100011;
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, JL = 7'b1101111;

  typedef struct { logic [3:0] st; bit mr; bit ret; } cyc_t;
  typedef struct { int sel; logic [6:0] op; logic [2:0] f3; bit z; int wf; int wm; int lat; int ntrap; } vec_t;

  cyc_t sched[$];
  int   total = 0, passed = 0;
  int   exp_ir = 0;

  function automatic logic [19:0] obs(int sel);
    if (sel == 0) return {st0, aop0, sa0, sb0, m2r0, pcs0, mrd0, mwr0, iod0, rw0, irw0, pcw0, ill0};
    return {st1, aop1, sa1, sb1, m2r1, pcs1, mrd1, mwr1, iod1, rw1, irw1, pcw1, ill1};
  endfunction

  function automatic logic [31:0] cur_ir(int sel);
    return (sel == 0) ? ir0 : {28'd0, ir1};
  endfunction

  // Expected control word per state, written straight from the state/strobe table.
  function automatic logic [19:0] exp_vec(logic [3:0] st, bit mr, bit z, logic [2:0] f3, bit we);
    logic [1:0] aop = 0, sa = 0, sb = 0, m2r = 0;
    bit pcs = 0, mrd = 0, mwr = 0, iod = 0, rw = 0, irw = 0, pcw = 0, ill = 0;
    case (st)
      4'd0:  begin sb = 2'b01; mrd = 1; irw = we ? mr : 1'b1; pcw = irw; end
      4'd1:  begin sa = 2'b10; sb = 2'b10; end
      4'd2:  begin sa = 2'b01; sb = 2'b10; end
      4'd3:  begin mrd = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 2'b01; end
      4'd5:  begin mwr = 1; iod = 1; end
      4'd6:  begin sa = 2'b01; aop = 2'b10; end
      4'd7:  begin sa = 2'b01; sb = 2'b10; aop = 2'b11; end
      4'd8:  rw = 1;
      4'd9:  begin sa = 2'b01; aop = 2'b01; pcs = 1; pcw = (f3 == 3'b000) ? z : !z; end
      4'd10: begin rw = 1; m2r = 2'b10; pcw = 1; pcs = 1; end
      default: ill = 1;
    endcase
    return {st, aop, sa, sb, m2r, pcs, mrd, mwr, iod, rw, irw, pcw, ill};
  endfunction

  function automatic void add(logic [3:0] st, bit mr, bit ret);
    sched.push_back('{st, mr, ret});
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic void add_mem(logic [3:0] st, int wm, bit we, bit ret);
    if (we) begin
      for (int i = 0; i < wm; i++) add(st, 1'b0, 1'b0);
      add(st, 1'b1, ret);
    end else add(st, 1'b0, ret);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Expand one instruction into its expected per-cycle schedule, then drive and compare.
  task automatic run(vec_t v);
    bit we = (v.sel == 0), je = (v.sel == 0);
    int cyc = 0, seen = 0;
    logic [31:0] ir_start;
    sched.delete();
    if (we) begin
      for (int i = 0; i < v.wf; i++) add(4'd0, 1'b0, 1'b0);
      add(4'd0, 1'b1, 1'b0);
    end else add(4'd0, 1'b0, 1'b0);
    add(4'd1, rb(), 1'b0);
    case (v.op)
      LD:  begin add(4'd2, rb(), 1'b0); add_mem(4'd3, v.wm, we, 1'b0); add(4'd4, rb(), 1'b1); end
      SD:  begin add(4'd2, rb(), 1'b0); add_mem(4'd5, v.wm, we, 1'b1); end
      OP:  begin add(4'd6, rb(), 1'b0); add(4'd8, rb(), 1'b1); end
      OPI: begin add(4'd7, rb(), 1'b0); add(4'd8, rb(), 1'b1); end
      BR:  if (v.f3 <= 3'd1) add(4'd9, rb(), 1'b1);
           else for (int i = 0; i < v.ntrap; i++) add(4'd11, rb(), 1'b0);
      JL:  if (je) add(4'd10, rb(), 1'b1);
           else for (int i = 0; i < v.ntrap; i++) add(4'd11, rb(), 1'b0);
      default: for (int i = 0; i < v.ntrap; i++) add(4'd11, rb(), 1'b0);
    endcase
    opcode = v.op; funct3 = v.f3; zero = v.z;
    ir_start = cur_ir(v.sel);
    foreach (sched[i]) begin
      mem_ready = sched[i].mr;
      @(negedge clock);
      chk($sformatf("ctl sel%0d st%0d", v.sel, sched[i].st), {12'd0, obs(v.sel)},
          {12'd0, exp_vec(sched[i].st, sched[i].mr, v.z, v.f3, we)});
      chk($sformatf("instret sel%0d", v.sel), cur_ir(v.sel),
          (v.sel == 0) ? exp_ir : (exp_ir & 32'hF));
      @(posedge clock); #1;
      if (sched[i].ret) exp_ir++;
      cyc++;
      if (seen == 0 && cur_ir(v.sel) != ir_start) seen = cyc;
    end
    if (v.lat > 0) chk($sformatf("latency op%b", v.op), seen, v.lat);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; mem_ready = 1'b1; opcode = OP;
    @(negedge clock);
    chk("reset u0", {12'd0, obs(0)}, {12'd0, exp_vec(4'd0, 1'b0, 1'b0, 3'd0, 1'b1)});
    chk("reset u1", {12'd0, obs(1)}, {12'd0, exp_vec(4'd0, 1'b0, 1'b0, 3'd0, 1'b1)});
    chk("reset instret", ir0 | {28'd0, ir1}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp_ir  = 0;
  endtask

  function automatic int base_lat(logic [6:0] op);
    case (op)
      LD: return 5;
      SD, OP, OPI: return 4;
      default: return 3;
    endcase
  endfunction

  vec_t tab[15];
  logic [6:0] pool[6];

  initial begin
    tab[0]  = '{0, OP,  3'd0, 0, 0, 0, 4, 0};
    tab[1]  = '{0, LD,  3'd2, 0, 0, 2, 7, 0};
    tab[2]  = '{0, SD,  3'd3, 0, 0, 1, 5, 0};
    tab[3]  = '{0, OPI, 3'd0, 1, 0, 0, 4, 0};
    tab[4]  = '{0, BR,  3'd0, 1, 0, 0, 3, 0};
    tab[5]  = '{0, BR,  3'd0, 0, 0, 0, 3, 0};
    tab[6]  = '{0, BR,  3'd1, 0, 0, 0, 3, 0};
    tab[7]  = '{0, BR,  3'd1, 1, 0, 0, 3, 0};
    tab[8]  = '{0, JL,  3'd0, 0, 0, 0, 3, 0};
    tab[9]  = '{0, OP,  3'd0, 0, 3, 0, 7, 0};
    tab[10] = '{0, BR,  3'd2, 0, 0, 0, 0, 6};
    tab[11] = '{1, OP,  3'd0, 0, 0, 0, 4, 0};
    tab[12] = '{1, LD,  3'd0, 0, 0, 0, 5, 0};
    tab[13] = '{1, SD,  3'd0, 0, 0, 0, 4, 0};
    tab[14] = '{1, JL,  3'd0, 0, 0, 0, 0, 10};
    pool = '{LD, SD, OP, OPI, BR, JL};
    funct3 = 3'd0; zero = 1'b0;

    do_reset();
    for (int i = 0; i < 11; i++) run(tab[i]);

    do_reset();
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.sel = 0; v.op = pool[$urandom_range(0, 5)];
      v.f3 = (v.op == BR) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      v.z = rb(); v.wf = $urandom_range(0, 3); v.wm = $urandom_range(0, 3); v.ntrap = 0;
      v.lat = base_lat(v.op) + v.wf + ((v.op == LD || v.op == SD) ? v.wm : 0);
      run(v);
    end
    run('{0, 7'b0000000, 3'd0, 0, 0, 0, 0, 4});

    do_reset();
    for (int i = 11; i < 15; i++) run(tab[i]);

    // 4-bit counter wraps after 16 retirements; then async reset mid-EXEC_R.
    do_reset();
    for (int n = 0; n < 17; n++) run('{1, OP, 3'd0, 0, 0, 0, 4, 0});
    chk("instret wrap", {28'd0, ir1}, 32'd1);
    opcode = OP; mem_ready = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    chk("mid EXEC_R", {28'd0, st1}, 32'd6);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset state", {28'd0, st1}, 32'd0);
    chk("async reset instret", {28'd0, ir1}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
